// File: rtl/ddr_stats_pkg.sv
// Shared constants and helpers for the DDR datamover stats monitors.
// Status byte layout and default counter widths live here.
package ddr_stats_pkg;

    localparam int DM_STS_OKAY_BIT = 7;
    localparam int DM_STS_ERR_MSB  = 6;
    localparam int DM_STS_ERR_LSB  = 4;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 48;
    localparam int DEF_BTT_WIDTH = 23;
    localparam int DEF_CMD_WIDTH = 72;

    // Error when OKAY is low or any of INTERR/DECERR/SLVERR is set.
    function automatic logic is_dm_sts_error(input logic [7:0] sts);
        return !sts[DM_STS_OKAY_BIT] ||
               (|sts[DM_STS_ERR_MSB:DM_STS_ERR_LSB]);
    endfunction

endpackage

// File: rtl/stats_counter.sv
// Wrapping event counter with synchronous clear.
// Clear wins over increment in the same cycle.
module stats_counter
    import ddr_stats_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             mem_clk,
    input  logic             mem_aresetn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count one per enabled cycle, modulo 2^WIDTH.
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dm_stream_stats.sv
// Passive monitor of one datamover direction (cmd/data/status).
// Never drives tready; all outputs are register outputs.
module dm_stream_stats
    import ddr_stats_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int CMD_WIDTH = DEF_CMD_WIDTH,
    parameter int BTT_WIDTH = DEF_BTT_WIDTH
) (
    input  logic                 mem_clk,
    input  logic                 mem_aresetn,
    input  logic                 clear,
    input  logic                 cmd_tvalid,
    input  logic                 cmd_tready,
    input  logic [CMD_WIDTH-1:0] cmd_tdata,
    input  logic                 data_tvalid,
    input  logic                 data_tready,
    input  logic                 data_tlast,
    input  logic                 sts_tvalid,
    input  logic                 sts_tready,
    input  logic [7:0]           sts_tdata,
    output logic [CNT_WIDTH-1:0] cmd_counter,
    output logic [CNT_WIDTH-1:0] word_counter,
    output logic [CNT_WIDTH-1:0] pkg_counter,
    output logic [LEN_WIDTH-1:0] length_counter,
    output logic [CNT_WIDTH-1:0] sts_counter,
    output logic [CNT_WIDTH-1:0] sts_error_counter,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 dm_error
);

    logic cmd_hs;
    logic data_hs;
    logic sts_hs;
    logic sts_err;
    logic underflow;

    logic [LEN_WIDTH-1:0] len_stage;
    logic                 len_vld;

    logic unused_bits;

    assign cmd_hs    = cmd_tvalid && cmd_tready;
    assign data_hs   = data_tvalid && data_tready;
    assign sts_hs    = sts_tvalid && sts_tready;
    assign sts_err   = sts_hs && is_dm_sts_error(sts_tdata);
    assign underflow = sts_hs && !cmd_hs && (outstanding == '0);

    assign unused_bits = ^{cmd_tdata[CMD_WIDTH-1:BTT_WIDTH],
                           sts_tdata[3:0]};

    stats_counter #(.WIDTH(CNT_WIDTH)) u_cmd_cnt (
        .mem_clk     (mem_clk),
        .mem_aresetn (mem_aresetn),
        .clear       (clear),
        .inc         (cmd_hs),
        .count       (cmd_counter)
    );

    stats_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
        .mem_clk     (mem_clk),
        .mem_aresetn (mem_aresetn),
        .clear       (clear),
        .inc         (data_hs),
        .count       (word_counter)
    );

    stats_counter #(.WIDTH(CNT_WIDTH)) u_pkg_cnt (
        .mem_clk     (mem_clk),
        .mem_aresetn (mem_aresetn),
        .clear       (clear),
        .inc         (data_hs && data_tlast),
        .count       (pkg_counter)
    );

    stats_counter #(.WIDTH(CNT_WIDTH)) u_sts_cnt (
        .mem_clk     (mem_clk),
        .mem_aresetn (mem_aresetn),
        .clear       (clear),
        .inc         (sts_hs),
        .count       (sts_counter)
    );

    stats_counter #(.WIDTH(CNT_WIDTH)) u_sts_err_cnt (
        .mem_clk     (mem_clk),
        .mem_aresetn (mem_aresetn),
        .clear       (clear),
        .inc         (sts_err),
        .count       (sts_error_counter)
    );

    // Stage 1: capture BTT; a pending value is dropped on clear.
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            len_stage <= '0;
            len_vld   <= 1'b0;
        end else if (clear) begin
            len_stage <= '0;
            len_vld   <= 1'b0;
        end else begin
            len_stage <= LEN_WIDTH'(cmd_tdata[BTT_WIDTH-1:0]);
            len_vld   <= cmd_hs;
        end
    end

    // Stage 2: accumulate captured BTT, wrapping.
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            length_counter <= '0;
        end else if (clear) begin
            length_counter <= '0;
        end else if (len_vld) begin
            length_counter <= length_counter + len_stage;
        end
    end

    // Commands in flight; a lone status at zero holds at zero.
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            outstanding <= '0;
        end else if (clear) begin
            outstanding <= '0;
        end else begin
            unique case (1'b1)
                cmd_hs && !sts_hs: outstanding <= outstanding + CNT_WIDTH'(1);
                sts_hs && !cmd_hs && !underflow:
                    outstanding <= outstanding - CNT_WIDTH'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky error on bad status or status underflow.
    always_ff @(posedge mem_clk or negedge mem_aresetn) begin
        if (!mem_aresetn) begin
            dm_error <= 1'b0;
        end else if (clear) begin
            dm_error <= 1'b0;
        end else if (sts_err || underflow) begin
            dm_error <= 1'b1;
        end
    end

endmodule
